gain_sequencer: RTL and testbench

GAIN_SEQUENCER -- requirements
Module: gain_sequencer

---
 rtl/gain_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_gain_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gain_sequencer
//  Description : Three-band gain stage. Each accepted band triple is scaled by
//                its per-band applied gain (Q3.4) on one shared 16x8 signed
//                multiplier, with floor shift and saturation. The applied
//                gains ramp toward loadable targets by at most RAMP_STEP LSBs
//                per output frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module gain_sequencer #(
  parameter int GAIN_FRAC = 4,
  parameter int RAMP_STEP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic signed [15:0] low_band,
  input  logic signed [15:0] mid_band,
  input  logic signed [15:0] high_band,
  input  logic signed [7:0]  gain_low,
  input  logic signed [7:0]  gain_mid,
  input  logic signed [7:0]  gain_high,
  input  logic               gain_load,
  output logic signed [15:0] low_out,
  output logic signed [15:0] mid_out,
  output logic signed [15:0] high_out,
  output logic               out_valid,
  output logic signed [7:0]  cur_gain_low,
  output logic signed [7:0]  cur_gain_mid,
  output logic signed [7:0]  cur_gain_high
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_LOW  = 3'd1,
    MUL_MID  = 3'd2,
    MUL_HIGH = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic signed [7:0]  c_unity      = 8'sd16;
  localparam logic signed [7:0]  c_ramp_step8 = 8'(RAMP_STEP);
  localparam logic signed [8:0]  c_ramp_step9 = 9'(RAMP_STEP);
  localparam logic signed [23:0] c_sat_max    = 24'sd32767;
  localparam logic signed [23:0] c_sat_min    = -24'sd32768;

  state_t state_q, state_d;

  logic signed [15:0] band_low_q, band_mid_q, band_high_q;
  logic signed [15:0] band_low_d, band_mid_d, band_high_d;
  logic signed [15:0] hold_low_q, hold_mid_q, hold_high_q;
  logic signed [15:0] hold_low_d, hold_mid_d, hold_high_d;
  logic signed [15:0] low_out_q, mid_out_q, high_out_q;
  logic signed [15:0] low_out_d, mid_out_d, high_out_d;
  logic               out_valid_q, out_valid_d;
  logic signed [7:0]  tgt_low_q, tgt_mid_q, tgt_high_q;
  logic signed [7:0]  tgt_low_d, tgt_mid_d, tgt_high_d;
  logic signed [7:0]  cur_low_q, cur_mid_q, cur_high_q;
  logic signed [7:0]  cur_low_d, cur_mid_d, cur_high_d;

  logic signed [15:0] mul_band;
  logic signed [7:0]  mul_gain;
  logic signed [23:0] product;
  logic signed [23:0] shifted;
  logic signed [15:0] sat_result;

  // Move one applied gain toward its target, landing exactly when within a step.
  function automatic logic signed [7:0] ramp_gain(input logic signed [7:0] cur,
                                                  input logic signed [7:0] tgt);
    logic signed [8:0] diff;
    diff = {tgt[7], tgt} - {cur[7], cur};
    if (diff > c_ramp_step9)
      ramp_gain = cur + c_ramp_step8;
    else if (diff < -c_ramp_step9)
      ramp_gain = cur - c_ramp_step8;
    else
      ramp_gain = tgt;
  endfunction

  assign sample_ready  = (state_q == IDLE);
  assign low_out       = low_out_q;
  assign mid_out       = mid_out_q;
  assign high_out      = high_out_q;
  assign out_valid     = out_valid_q;
  assign cur_gain_low  = cur_low_q;
  assign cur_gain_mid  = cur_mid_q;
  assign cur_gain_high = cur_high_q;

  // Shared multiplier: operand select by state, floor shift, then saturate.
  always_comb begin
    mul_band = band_low_q;
    mul_gain = cur_low_q;
    case (state_q)
      MUL_MID: begin
        mul_band = band_mid_q;
        mul_gain = cur_mid_q;
      end
      MUL_HIGH: begin
        mul_band = band_high_q;
        mul_gain = cur_high_q;
      end
      default: ;
    endcase
    product = mul_band * mul_gain;
    shifted = product >>> GAIN_FRAC;
    if (shifted > c_sat_max)
      sat_result = 16'sh7FFF;
    else if (shifted < c_sat_min)
      sat_result = 16'sh8000;
    else
      sat_result = shifted[15:0];
  end

  // Next-state, datapath latching, output update and gain ramp.
  always_comb begin
    state_d     = state_q;
    band_low_d  = band_low_q;
    band_mid_d  = band_mid_q;
    band_high_d = band_high_q;
    hold_low_d  = hold_low_q;
    hold_mid_d  = hold_mid_q;
    hold_high_d = hold_high_q;
    low_out_d   = low_out_q;
    mid_out_d   = mid_out_q;
    high_out_d  = high_out_q;
    out_valid_d = 1'b0;
    tgt_low_d   = tgt_low_q;
    tgt_mid_d   = tgt_mid_q;
    tgt_high_d  = tgt_high_q;
    cur_low_d   = cur_low_q;
    cur_mid_d   = cur_mid_q;
    cur_high_d  = cur_high_q;

    // Targets load on any edge; the ramp below reads the pre-load values.
    if (gain_load) begin
      tgt_low_d  = gain_low;
      tgt_mid_d  = gain_mid;
      tgt_high_d = gain_high;
    end

    case (state_q)
      IDLE: begin
        if (sample_valid && sample_ready) begin
          band_low_d  = low_band;
          band_mid_d  = mid_band;
          band_high_d = high_band;
          state_d     = MUL_LOW;
        end
      end
      MUL_LOW: begin
        hold_low_d = sat_result;
        state_d    = MUL_MID;
      end
      MUL_MID: begin
        hold_mid_d = sat_result;
        state_d    = MUL_HIGH;
      end
      MUL_HIGH: begin
        hold_high_d = sat_result;
        state_d     = DONE;
      end
      DONE: begin
        low_out_d   = hold_low_q;
        mid_out_d   = hold_mid_q;
        high_out_d  = hold_high_q;
        out_valid_d = 1'b1;
        cur_low_d   = ramp_gain(cur_low_q, tgt_low_q);
        cur_mid_d   = ramp_gain(cur_mid_q, tgt_mid_q);
        cur_high_d  = ramp_gain(cur_high_q, tgt_high_q);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      band_low_q  <= '0;
      band_mid_q  <= '0;
      band_high_q <= '0;
      hold_low_q  <= '0;
      hold_mid_q  <= '0;
      hold_high_q <= '0;
      low_out_q   <= '0;
      mid_out_q   <= '0;
      high_out_q  <= '0;
      out_valid_q <= 1'b0;
      tgt_low_q   <= c_unity;
      tgt_mid_q   <= c_unity;
      tgt_high_q  <= c_unity;
      cur_low_q   <= c_unity;
      cur_mid_q   <= c_unity;
      cur_high_q  <= c_unity;
    end else begin
      state_q     <= state_d;
      band_low_q  <= band_low_d;
      band_mid_q  <= band_mid_d;
      band_high_q <= band_high_d;
      hold_low_q  <= hold_low_d;
      hold_mid_q  <= hold_mid_d;
      hold_high_q <= hold_high_d;
      low_out_q   <= low_out_d;
      mid_out_q   <= mid_out_d;
      high_out_q  <= high_out_d;
      out_valid_q <= out_valid_d;
      tgt_low_q   <= tgt_low_d;
      tgt_mid_q   <= tgt_mid_d;
      tgt_high_q  <= tgt_high_d;
      cur_low_q   <= cur_low_d;
      cur_mid_q   <= cur_mid_d;
      cur_high_q  <= cur_high_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gain_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gain_sequencer
//  Description : Directed self-checking bench for gain_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gain_sequencer;

  logic               clk;
  logic               reset;
  logic               sample_valid;
  logic               sample_ready;
  logic signed [15:0] low_band, mid_band, high_band;
  logic signed [7:0]  gain_low, gain_mid, gain_high;
  logic               gain_load;
  logic signed [15:0] low_out, mid_out, high_out;
  logic               out_valid;
  logic signed [7:0]  cur_gain_low, cur_gain_mid, cur_gain_high;

  int checks   = 0;
  int failures = 0;

  gain_sequencer #(.GAIN_FRAC(4), .RAMP_STEP(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .low_band     (low_band),
    .mid_band     (mid_band),
    .high_band    (high_band),
    .gain_low     (gain_low),
    .gain_mid     (gain_mid),
    .gain_high    (gain_high),
    .gain_load    (gain_load),
    .low_out      (low_out),
    .mid_out      (mid_out),
    .high_out     (high_out),
    .out_valid    (out_valid),
    .cur_gain_low (cur_gain_low),
    .cur_gain_mid (cur_gain_mid),
    .cur_gain_high(cur_gain_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_gains(input int gl, input int gm, input int gh);
    gain_low  = 8'(gl);
    gain_mid  = 8'(gm);
    gain_high = 8'(gh);
    gain_load = 1'b1;
    tick();
    gain_load = 1'b0;
  endtask

  // One frame: accept edge, four busy cycles, then the out_valid cycle.
  // Optionally pulses gain_load during the DONE cycle.
  task automatic run_frame(input int lo, input int mi, input int hi,
                           input bit ld, input int gl, input int gm, input int gh);
    low_band     = 16'(lo);
    mid_band     = 16'(mi);
    high_band    = 16'(hi);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("busy_ready", sample_ready, 0);
      check("busy_out_valid", out_valid, 0);
      if (ld && i == 3) begin
        gain_low  = 8'(gl);
        gain_mid  = 8'(gm);
        gain_high = 8'(gh);
        gain_load = 1'b1;
      end
      tick();
      gain_load = 1'b0;
    end
    check("frame_out_valid", out_valid, 1);
    check("frame_ready", sample_ready, 1);
  endtask

  function automatic int d_low(input int c);  return 100 * c + 3;  endfunction
  function automatic int d_mid(input int c);  return -50 * c - 1;  endfunction
  function automatic int d_high(input int c); return 7 * c;        endfunction

  initial begin
    int g;
    int b;
    reset        = 1'b1;
    sample_valid = 1'b0;
    low_band     = '0;
    mid_band     = '0;
    high_band    = '0;
    gain_low     = '0;
    gain_mid     = '0;
    gain_high    = '0;
    gain_load    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_low_out", low_out, 0);
    check("rst_mid_out", mid_out, 0);
    check("rst_high_out", high_out, 0);
    check("rst_cur_low", cur_gain_low, 16);
    check("rst_cur_mid", cur_gain_mid, 16);
    check("rst_cur_high", cur_gain_high, 16);
    reset = 1'b0;
    check("rst_ready", sample_ready, 1);

    // Unity frame with a full-scale positive sample
    run_frame(1000, -2000, 32767, 0, 0, 0, 0);
    check("unity_low", low_out, 1000);
    check("unity_mid", mid_out, -2000);
    check("unity_high", high_out, 32767);
    tick();
    check("unity_pulse_end", out_valid, 0);
    check("unity_hold_low", low_out, 1000);

    // Ramp of the low gain from 16 to 32, one LSB per frame
    load_gains(32, 16, 16);
    check("load_no_immediate", cur_gain_low, 16);
    for (int k = 1; k <= 18; k++) begin
      b = 1001 - 150 * k;
      g = (15 + k < 32) ? 15 + k : 32;
      run_frame(b, 500, -7, 0, 0, 0, 0);
      check("ramp_low_out", low_out, (b * g) >>> 4);
      check("ramp_mid_out", mid_out, 500);
      check("ramp_high_out", high_out, -7);
      check("ramp_cur_low", cur_gain_low, (16 + k < 32) ? 16 + k : 32);
    end

    // Saturation and floor at gains 32/32/8
    load_gains(32, 32, 8);
    for (int k = 0; k < 16; k++) run_frame(0, 0, 0, 0, 0, 0, 0);
    check("sat_cur_low", cur_gain_low, 32);
    check("sat_cur_mid", cur_gain_mid, 32);
    check("sat_cur_high", cur_gain_high, 8);
    run_frame(30000, -30000, -1, 0, 0, 0, 0);
    check("sat_low_pos", low_out, 32767);
    check("sat_mid_neg", mid_out, -32768);
    check("floor_high", high_out, -1);

    // Gain load coinciding with the DONE edge
    load_gains(32, 20, 8);
    run_frame(0, 0, 0, 0, 0, 0, 0);
    check("sim_cur_mid_a", cur_gain_mid, 31);
    run_frame(0, 1000, 0, 1, 32, 40, 8);
    check("sim_mid_out_b", mid_out, 1937);
    check("sim_cur_mid_b", cur_gain_mid, 30);
    run_frame(0, 1000, 0, 0, 0, 0, 0);
    check("sim_mid_out_c", mid_out, 1875);
    check("sim_cur_mid_c", cur_gain_mid, 31);

    // Reset while in MUL_MID
    low_band     = 16'sd1111;
    mid_band     = 16'sd2222;
    high_band    = 16'sd3333;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_low_out", low_out, 0);
    check("mrst_mid_out", mid_out, 0);
    check("mrst_high_out", high_out, 0);
    check("mrst_cur_low", cur_gain_low, 16);
    check("mrst_cur_mid", cur_gain_mid, 16);
    check("mrst_cur_high", cur_gain_high, 16);
    tick();
    tick();
    check("mrst_out_valid_held", out_valid, 0);
    reset = 1'b0;
    check("mrst_ready_after", sample_ready, 1);

    // Continuous sample_valid with data changing every cycle
    sample_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      low_band  = 16'(d_low(c));
      mid_band  = 16'(d_mid(c));
      high_band = 16'(d_high(c));
      tick();
      check("busy_hold_out_valid", out_valid, (c % 5 == 4) ? 1 : 0);
      check("busy_hold_ready", sample_ready, (c % 5 == 4) ? 1 : 0);
      if (c % 5 == 4) begin
        check("busy_hold_low", low_out, d_low(c - 4));
        check("busy_hold_mid", mid_out, d_mid(c - 4));
        check("busy_hold_high", high_out, d_high(c - 4));
        check("busy_hold_cur", cur_gain_mid, 16);
      end
    end
    sample_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
